// File: rtl/instruction_sequencer.sv
// Fetch/issue stage that feeds the control unit. It reads instruction words from a
// synchronous program ROM and presents opcode/operand for a fixed number of cycles.
// It also owns the program counter, HALT detection, stop requests, wrap-around and
// single-step.
module instruction_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int PROG_LEN    = 16,
    parameter int EXEC_CYCLES = 2,
    parameter int WRAP        = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              step_en,
    input  logic              step,
    input  logic [7:0]        progData,
    output logic [ADDR_W-1:0] progAddr,
    output logic              progRd,
    output logic [3:0]        opCode,
    output logic [3:0]        operand,
    output logic              issueValid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic [15:0]       instrCount
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        ISSUE,
        PAUSE,
        HALTED
    } state_t;

    localparam int                CNT_W     = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_LEN - 1);
    localparam logic [3:0]        HALT_OP   = 4'b1111;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [7:0]         ir_q, ir_d;
    logic               stopPend_q, stopPend_d;
    logic [CNT_W-1:0]   execCnt_q, execCnt_d;
    logic [15:0]        count_q, count_d;

    logic [ADDR_W-1:0]  pcNext;
    logic               lastIssue;
    logic [15:0]        countInc;

    // Program counter advances modulo the program length, the issue counter saturates.
    assign pcNext    = (pc_q == LAST_ADDR) ? '0 : pc_q + ADDR_W'(1);
    assign lastIssue = (execCnt_q == LAST_CNT);
    assign countInc  = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    // State and datapath registers; reset returns everything to an idle NOP state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ir_q       <= 8'hFF;
            stopPend_q <= 1'b0;
            execCnt_q  <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            stopPend_q <= stopPend_d;
            execCnt_q  <= execCnt_d;
            count_q    <= count_d;
        end
    end

    // Next-state logic: sequence fetch/latch/issue and decide where each instruction leads.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        stopPend_d = stopPend_q;
        execCnt_d  = execCnt_q;
        count_d    = count_q;
        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d    = FETCH;
                    pc_d       = '0;
                    count_d    = '0;
                    stopPend_d = stop;
                end
            end
            FETCH: begin
                if (stop) stopPend_d = 1'b1;
                state_d = LATCH;
            end
            LATCH: begin
                if (stop) stopPend_d = 1'b1;
                ir_d      = progData;
                execCnt_d = '0;
                state_d   = ISSUE;
            end
            ISSUE: begin
                if (stop) stopPend_d = 1'b1;
                if (!lastIssue) begin
                    execCnt_d = execCnt_q + CNT_W'(1);
                end else begin
                    count_d = countInc;
                    if (ir_q[7:4] == HALT_OP) begin
                        state_d = HALTED;
                    end else if (stopPend_q || stop) begin
                        state_d = HALTED;
                        pc_d    = pcNext;
                    end else if ((pc_q == LAST_ADDR) && (WRAP == 0)) begin
                        state_d = HALTED;
                    end else begin
                        pc_d    = pcNext;
                        state_d = step_en ? PAUSE : FETCH;
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d = HALTED;
                end else if (step || !step_en) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: only ISSUE exposes a live instruction, everything else shows a NOP.
    always_comb begin
        progRd     = 1'b0;
        opCode     = HALT_OP;
        operand    = 4'h0;
        issueValid = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        case (state_q)
            FETCH: begin
                progRd = 1'b1;
                busy   = 1'b1;
            end
            LATCH: busy = 1'b1;
            ISSUE: begin
                opCode     = ir_q[7:4];
                operand    = ir_q[3:0];
                issueValid = 1'b1;
                busy       = 1'b1;
            end
            PAUSE:   busy   = 1'b1;
            HALTED:  halted = 1'b1;
            default: ;
        endcase
    end

    assign progAddr   = pc_q;
    assign pc         = pc_q;
    assign instrCount = count_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: one default instance plus two small four-word
// instances (wrapping and non-wrapping), checked by directed expectations and by a
// per-cycle program-level model.
module tb_instruction_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, stop, step_en, step, startW, stopW, startN;
    logic [7:0]  progData, progDataW, progDataN;

    logic [3:0]  progAddr, pc, opCode, operand;
    logic        progRd, issueValid, busy, halted;
    logic [15:0] instrCount;

    logic [3:0]  progAddrW, pcW, opCodeW, operandW;
    logic        progRdW, issueValidW, busyW, haltedW;
    logic [15:0] instrCountW;

    logic [3:0]  progAddrN, pcN, opCodeN, operandN;
    logic        progRdN, issueValidN, busyN, haltedN;
    logic [15:0] instrCountN;

    logic [7:0]  rom [16];
    logic [7:0]  romW[16];
    logic [7:0]  romN[16];

    int checks = 0;
    int errors = 0;
    int expPcQ[$];
    int mPc, mCnt;

    instruction_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step_en(step_en), .step(step),
        .progData(progData), .progAddr(progAddr), .progRd(progRd), .opCode(opCode),
        .operand(operand), .issueValid(issueValid), .pc(pc), .busy(busy), .halted(halted),
        .instrCount(instrCount)
    );

    instruction_sequencer #(.ADDR_W(4), .PROG_LEN(4), .EXEC_CYCLES(2), .WRAP(1)) dutW (
        .clk(clk), .rst(rst), .start(startW), .stop(stopW), .step_en(1'b0), .step(1'b0),
        .progData(progDataW), .progAddr(progAddrW), .progRd(progRdW), .opCode(opCodeW),
        .operand(operandW), .issueValid(issueValidW), .pc(pcW), .busy(busyW), .halted(haltedW),
        .instrCount(instrCountW)
    );

    instruction_sequencer #(.ADDR_W(4), .PROG_LEN(4), .EXEC_CYCLES(2), .WRAP(0)) dutN (
        .clk(clk), .rst(rst), .start(startN), .stop(1'b0), .step_en(1'b0), .step(1'b0),
        .progData(progDataN), .progAddr(progAddrN), .progRd(progRdN), .opCode(opCodeN),
        .operand(operandN), .issueValid(issueValidN), .pc(pcN), .busy(busyN), .halted(haltedN),
        .instrCount(instrCountN)
    );

    // Synchronous program ROMs: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (progRd)  progData  <= rom[progAddr];
        if (progRdW) progDataW <= romW[progAddrW];
        if (progRdN) progDataN <= romN[progAddrN];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of pulses, then release them.
    task automatic applyStimulus(input logic st, input logic sp, input logic stp,
                                 input logic stW, input logic spW, input logic stN);
        start  = st;
        stop   = sp;
        step   = stp;
        startW = stW;
        stopW  = spW;
        startN = stN;
        tick();
        start  = 1'b0;
        stop   = 1'b0;
        step   = 1'b0;
        startW = 1'b0;
        stopW  = 1'b0;
        startN = 1'b0;
    endtask

    function automatic logic haltedOf(input int which);
        case (which)
            0:       return halted;
            1:       return haltedW;
            default: return haltedN;
        endcase
    endfunction

    task automatic waitHalted(input int which, input string name);
        for (int i = 0; i < 400; i++) begin
            if (haltedOf(which)) return;
            tick();
        end
        timeoutFail(name);
    endtask

    task automatic waitIssueDone(input string name);
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (issueValid) begin
                seen = 1;
                break;
            end
            tick();
        end
        if (!seen) begin
            timeoutFail(name);
            return;
        end
        for (int i = 0; i < 50; i++) begin
            if (!issueValid) return;
            tick();
        end
        timeoutFail(name);
    endtask

    // Program-level model: walk the program from address 0 until HALT or the last word.
    task automatic modelRun(input int maxIssues, output int finalPc, output int count);
        int p = 0;
        count = 0;
        for (int n = 0; n < maxIssues; n++) begin
            expPcQ.push_back(p);
            count++;
            if (rom[p][7:4] == 4'hF) break;
            if (p == 15) break;
            p++;
        end
        finalPc = p;
    endtask

    logic prevV = 1'b0, prevW = 1'b0, prevN = 1'b0;
    int   runLen = 0, wIssues = 0, nIssues = 0;

    // Per-cycle compare against the program contents and the expected issue order.
    always @(negedge clk) begin
        if (issueValid)
            checkOutput("mainIssueWord", 32'({opCode, operand}), 32'(rom[pc]));
        else
            checkOutput("mainIdleWord", 32'({opCode, operand}), 32'h0F0);
        if (issueValid && !prevV) begin
            if (expPcQ.size() == 0) timeoutFail("mainUnexpectedIssue");
            else checkOutput("mainIssuePc", 32'(pc), expPcQ.pop_front());
        end
        if (issueValid) begin
            runLen++;
        end else if (prevV) begin
            checkOutput("mainIssueLen", runLen, 2);
            runLen = 0;
        end
        checkOutput("mainBusyHalted", 32'(busy && halted), 0);

        if (issueValidW) begin
            checkOutput("wrapIssueWord", 32'({opCodeW, operandW}), 32'(romW[pcW]));
            if (!prevW) begin
                checkOutput("wrapIssuePc", 32'(pcW), wIssues % 4);
                wIssues++;
            end
        end else begin
            checkOutput("wrapIdleOp", 32'(opCodeW), 32'hF);
        end

        if (issueValidN) begin
            checkOutput("noWrapIssueWord", 32'({opCodeN, operandN}), 32'(romN[pcN]));
            if (!prevN) begin
                checkOutput("noWrapIssuePc", 32'(pcN), nIssues);
                nIssues++;
            end
        end

        prevV = issueValid;
        prevW = issueValidW;
        prevN = issueValidN;
    end

    // Directed scenarios.
    initial begin
        bit reached;
        rst = 1'b1; start = 1'b0; stop = 1'b0; step_en = 1'b0; step = 1'b0;
        startW = 1'b0; stopW = 1'b0; startN = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rom[i]  = 8'hA1;
            romW[i] = 8'hFF;
            romN[i] = 8'hFF;
        end
        rom[0] = 8'h25; rom[1] = 8'h37; rom[2] = 8'h0F; rom[3] = 8'hF0;
        romW[0] = 8'h12; romW[1] = 8'h34; romW[2] = 8'h56; romW[3] = 8'h78;
        romN[0] = 8'h9A; romN[1] = 8'hBC; romN[2] = 8'hDE; romN[3] = 8'h41;

        tick();
        tick();
        checkOutput("rstOpCode", 32'(opCode), 32'hF);
        checkOutput("rstOperand", 32'(operand), 0);
        checkOutput("rstIssueValid", 32'(issueValid), 0);
        checkOutput("rstPc", 32'(pc), 0);
        checkOutput("rstProgAddr", 32'(progAddr), 0);
        checkOutput("rstProgRd", 32'(progRd), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstHalted", 32'(halted), 0);
        checkOutput("rstInstrCount", 32'(instrCount), 0);
        rst = 1'b0;
        tick();

        $display("[TB] wrap / no-wrap four-word programs");
        applyStimulus(0, 0, 0, 1, 0, 1);
        reached = 0;
        for (int i = 0; i < 400; i++) begin
            if (wIssues >= 10) begin
                reached = 1;
                break;
            end
            tick();
        end
        if (!reached) timeoutFail("wrapTenIssues");
        applyStimulus(0, 0, 0, 0, 1, 0);
        waitHalted(1, "wrapHaltWait");
        waitHalted(2, "noWrapHaltWait");
        checkOutput("wrapHalted", 32'(haltedW), 1);
        checkOutput("wrapBusy", 32'(busyW), 0);
        checkOutput("wrapCount", 32'(instrCountW), 10);
        checkOutput("wrapPcModel", 32'(pcW), 32'(instrCountW) % 4);
        checkOutput("wrapPc", 32'(pcW), 2);
        checkOutput("noWrapHalted", 32'(haltedN), 1);
        checkOutput("noWrapIssues", nIssues, 4);
        checkOutput("noWrapCount", 32'(instrCountN), 4);
        checkOutput("noWrapPc", 32'(pcN), 3);

        $display("[TB] main program to HALT");
        modelRun(100, mPc, mCnt);
        checkOutput("modelPinPc", mPc, 3);
        checkOutput("modelPinCount", mCnt, 4);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("fetchProgRd", 32'(progRd), 1);
        checkOutput("fetchBusy", 32'(busy), 1);
        checkOutput("fetchAddr", 32'(progAddr), 0);
        checkOutput("fetchIssueValid", 32'(issueValid), 0);
        tick();
        checkOutput("latchIssueValid", 32'(issueValid), 0);
        checkOutput("latchProgRd", 32'(progRd), 0);
        tick();
        checkOutput("firstIssueValid", 32'(issueValid), 1);
        checkOutput("firstOpCode", 32'(opCode), 2);
        checkOutput("firstOperand", 32'(operand), 5);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0);
        waitHalted(0, "mainHaltWait");
        checkOutput("haltHalted", 32'(halted), 1);
        checkOutput("haltBusy", 32'(busy), 0);
        checkOutput("haltPc", 32'(pc), 3);
        checkOutput("haltPcModel", 32'(pc), mPc);
        checkOutput("haltCount", 32'(instrCount), 4);
        checkOutput("haltCountModel", 32'(instrCount), mCnt);
        checkOutput("haltQueueEmpty", expPcQ.size(), 0);

        $display("[TB] stop during LATCH of instruction 1");
        expPcQ.push_back(0);
        expPcQ.push_back(1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        reached = 0;
        for (int i = 0; i < 50; i++) begin
            if (progRd && pc == 4'd1) begin
                reached = 1;
                break;
            end
            tick();
        end
        if (!reached) timeoutFail("stopFetch1Wait");
        tick();
        applyStimulus(0, 1, 0, 0, 0, 0);
        waitHalted(0, "stopHaltWait");
        checkOutput("stopPc", 32'(pc), 2);
        checkOutput("stopCount", 32'(instrCount), 2);
        checkOutput("stopQueueEmpty", expPcQ.size(), 0);

        $display("[TB] single-step mode");
        step_en = 1'b1;
        expPcQ.push_back(0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        waitIssueDone("step0Issue");
        checkOutput("pauseBusy", 32'(busy), 1);
        checkOutput("pauseIssueValid", 32'(issueValid), 0);
        checkOutput("pauseOpCode", 32'(opCode), 32'hF);
        checkOutput("pausePc", 32'(pc), 1);
        tick();
        tick();
        tick();
        checkOutput("pauseHoldValid", 32'(issueValid), 0);
        checkOutput("pauseHoldCount", 32'(instrCount), 1);
        expPcQ.push_back(1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        waitIssueDone("step1Issue");
        checkOutput("step1Pc", 32'(pc), 2);
        checkOutput("step1Count", 32'(instrCount), 2);
        checkOutput("step1Busy", 32'(busy), 1);
        applyStimulus(0, 1, 1, 0, 0, 0);
        checkOutput("stepStopHalted", 32'(halted), 1);
        checkOutput("stepStopPc", 32'(pc), 2);
        checkOutput("stepStopCount", 32'(instrCount), 2);
        step_en = 1'b0;
        checkOutput("stepQueueEmpty", expPcQ.size(), 0);

        $display("[TB] reset during second ISSUE cycle");
        expPcQ.push_back(0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        reached = 0;
        for (int i = 0; i < 50; i++) begin
            if (issueValid) begin
                reached = 1;
                break;
            end
            tick();
        end
        if (!reached) timeoutFail("rstIssueWait");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midRstOpCode", 32'(opCode), 32'hF);
        checkOutput("midRstOperand", 32'(operand), 0);
        checkOutput("midRstIssueValid", 32'(issueValid), 0);
        checkOutput("midRstPc", 32'(pc), 0);
        checkOutput("midRstBusy", 32'(busy), 0);
        checkOutput("midRstHalted", 32'(halted), 0);
        checkOutput("midRstCount", 32'(instrCount), 0);
        tick();
        modelRun(100, mPc, mCnt);
        applyStimulus(1, 0, 0, 0, 0, 0);
        waitHalted(0, "rerunHaltWait");
        checkOutput("rerunPc", 32'(pc), mPc);
        checkOutput("rerunCount", 32'(instrCount), mCnt);
        checkOutput("rerunQueueEmpty", expPcQ.size(), 0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
